// File: rtl/apb_requester.sv
// apb_requester: single-channel APB requester that runs one command at a time through SETUP/ACCESS.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_write, cmd_addr, cmd_wdata describe it
//   rsp_valid/rsp_ready           response handshake; rsp_rdata, rsp_slverr, rsp_timeout describe it
//   psel, penable, pwrite         APB control
//   paddr, pwdata                 APB address and write data
//   prdata, pready, pslverr       APB completer returns
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    // Counter value on the last allowed wait cycle; this cycle aborts unless pready is high.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    logic [1:0]    state;
    logic [CW-1:0] wcnt;
    logic          expired;
    assign expired   = (TIMEOUT != 0) && (wcnt == LAST);
    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = state == ACCESS;
    // paddr/pwrite/pwdata are the command registers themselves; pwdata only loads on writes
    // so it keeps the last written value through reads and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    pwrite <= cmd_write;
                    paddr  <= cmd_addr;
                    pwdata <= cmd_write ? cmd_wdata : pwdata;
                    wcnt   <= '0;
                    state  <= SETUP;
                end
                SETUP: state <= ACCESS;
                ACCESS: if (pready) begin
                    rsp_rdata   <= pwrite ? '0 : prdata;
                    rsp_slverr  <= pslverr;
                    rsp_timeout <= 1'b0;
                    state       <= RESP;
                end else if (expired) begin
                    rsp_rdata   <= '0;
                    rsp_slverr  <= 1'b1;
                    rsp_timeout <= 1'b1;
                    state       <= RESP;
                end else begin
                    wcnt <= (wcnt == '1) ? wcnt : wcnt + 1'b1;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed scoreboard bench for apb_requester against a small APB RAM model.
module tb_apb_requester;
    logic        clk = 0, rst = 0;
    logic        cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    int          checks = 0, failures = 0;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // APB RAM completer: 16 words below 0x40, error above, programmable wait states or hang.
    logic [31:0] smem [16];
    logic [3:0]  scnt = 0;
    logic [3:0]  waits = 0;
    logic        hang = 0;
    assign pready  = psel & penable & ~hang & (scnt == waits);
    assign pslverr = pready & (paddr >= 32'h40);
    assign prdata  = (paddr < 32'h40) ? smem[paddr[5:2]] : 32'h0;
    always @(posedge clk) begin
        scnt <= (psel & penable & ~pready) ? scnt + 4'd1 : 4'd0;
        if (pready & pwrite & (paddr < 32'h40)) smem[paddr[5:2]] <= pwdata;
    end

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        err;
        logic        tmo;
    } exp_t;
    exp_t        q[$];
    logic [31:0] exp_mem [16];
    logic [31:0] last_wd = 0, cur_a = 0;
    logic        cur_w = 0;
    int          k;

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic wait_accept(output int n);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", cmd_ready, 1);
        @(posedge clk);
        q.push_back('{cmd_write, cmd_addr, cmd_wdata, cmd_addr >= 32'h40, hang});
        cur_a = cmd_addr;
        cur_w = cmd_write;
        if (cmd_write) last_wd = cmd_wdata;
    endtask

    task automatic issue(logic w, logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        cmd_valid = 1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        wait_accept(k);
    endtask

    task automatic follow(int acc, logic nv, logic nw, logic [31:0] na, logic [31:0] nd);
        @(negedge clk);
        cmd_valid = nv;
        if (nv) begin
            cmd_write = nw;
            cmd_addr  = na;
            cmd_wdata = nd;
        end
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, cur_a);
        chk("setup_pwrite", pwrite, cur_w);
        chk("busy_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < acc; i++) begin
            @(negedge clk);
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_paddr", paddr, cur_a);
            chk("access_pwdata", pwdata, last_wd);
            chk("access_no_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_psel", psel, 0);
        chk("resp_penable", penable, 0);
    endtask

    task automatic finish(int delay);
        exp_t        e;
        logic [31:0] er;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e  = q.pop_front();
        er = (e.w || e.err || e.tmo) ? 32'h0 : exp_mem[e.a[5:2]];
        if (e.w && !e.err && !e.tmo) exp_mem[e.a[5:2]] = e.d;
        chk("rsp_rdata", rsp_rdata, er);
        chk("rsp_slverr", rsp_slverr, e.err | e.tmo);
        chk("rsp_timeout", rsp_timeout, e.tmo);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, er);
            chk("bp_slverr", rsp_slverr, e.err | e.tmo);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_psel", psel, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_slverr", rsp_slverr, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        // zero-wait write
        waits = 0;
        issue(1, 32'h8, 32'h1234_5678);
        follow(1, 0, 0, 0, 0);
        finish(0);
        chk("slave_mem8", smem[2], 32'h1234_5678);
        // read with two wait states
        waits = 2;
        issue(0, 32'h8, 32'h0);
        follow(3, 0, 0, 0, 0);
        finish(0);
        // completer error on out-of-range write
        waits = 0;
        issue(1, 32'h100, 32'h0000_dead);
        follow(1, 0, 0, 0, 0);
        finish(0);
        // timeout with pready held low
        hang = 1;
        issue(0, 32'h4, 32'h0);
        follow(4, 0, 0, 0, 0);
        finish(0);
        hang = 0;
        // backpressure with the next command waiting
        waits = 1;
        issue(1, 32'h10, 32'ha5a5_a5a5);
        follow(2, 1, 0, 32'h10, 32'h0);
        finish(5);
        waits = 0;
        wait_accept(k);
        chk("second_accept_delay", k, 0);
        follow(1, 0, 0, 0, 0);
        finish(0);
        // reset during ACCESS
        hang = 1;
        issue(1, 32'h14, 32'h0000_0777);
        @(negedge clk);
        cmd_valid = 0;
        chk("rstx_setup_psel", psel, 1);
        @(negedge clk);
        chk("rstx_access_penable", penable, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstx_psel", psel, 0);
        chk("rstx_penable", penable, 0);
        chk("rstx_cmd_ready", cmd_ready, 1);
        chk("rstx_rsp_valid", rsp_valid, 0);
        if (q.size() > 0) q.delete(q.size() - 1);
        last_wd = 0;
        hang = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstx_quiet", rsp_valid, 0);
        end
        issue(1, 32'h14, 32'h0000_0055);
        follow(1, 0, 0, 0, 0);
        finish(0);
        issue(0, 32'h14, 32'h0);
        follow(1, 0, 0, 0, 0);
        finish(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
